chase_motor_ctrl: RTL and testbench

- Closed-loop chase controller between the filtered target tracker (x, radius) and the two drive-motor H-bridges.
- On each camera frame it turns the target position and size errors into a drive decision: turn, forward, reverse, hold, search or stop.
- Drives per-wheel direction bits and PWM outputs, with a frame watchdog and lost-target search.

---
 rtl/chase_pkg.sv | 37 +++
 rtl/pwm_gen.sv | 49 ++++
 rtl/chase_motor_ctrl.sv | 139 +++++++++++++
 tb/tb_chase_motor_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chase_pkg.sv
// rtl/chase_pkg.sv - shared states, duty width and error-to-duty helpers for chase_motor_ctrl
package chase_pkg;

  localparam int DUTY_W    = 8;
  localparam int SLEW_STEP = 16;

  typedef enum logic [2:0] {
    STOP   = 3'd0,
    HOLD   = 3'd1,
    TURN_L = 3'd2,
    TURN_R = 3'd3,
    FWD    = 3'd4,
    REV    = 3'd5,
    SEARCH = 3'd6
  } state_t;

  function automatic logic [9:0] abs10(input logic signed [9:0] v);
    return v[9] ? 10'(-v) : 10'(v);
  endfunction

  // Magnitude is taken before the shift so negative errors scale identically.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [9:0] err,
                                                 input int shift, input int dmax);
    logic [17:0] scaled;
    scaled = {8'd0, abs10(err)} << shift;
    return (scaled > 18'(dmax)) ? DUTY_W'(dmax) : scaled[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] slew_step(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt);
    if (tgt > cur)
      return (tgt - cur > DUTY_W'(SLEW_STEP)) ? cur + DUTY_W'(SLEW_STEP) : tgt;
    else
      return (cur - tgt > DUTY_W'(SLEW_STEP)) ? cur - DUTY_W'(SLEW_STEP) : tgt;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - one wheel PWM: free-running counter, duty/dir loaded only at wrap
// Optional SLEW_LIMIT_EN ramps duty by 16 per period and ramps through zero on reversal.
module pwm_gen
  import chase_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              stop,
  output logic              pwm,
  output logic              act_dir
);

  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] act_duty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      act_duty <= '0;
      act_dir  <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
`ifdef SLEW_LIMIT_EN
      if (stop) begin
        act_duty <= '0;
        if (&cnt) act_dir <= cmd_dir;
      end else if (&cnt) begin
        if (cmd_dir != act_dir) begin
          // Reversal: run down to zero first, flip only on a period that is already idle.
          if (act_duty == '0) act_dir <= cmd_dir;
          else act_duty <= slew_step(act_duty, {DUTY_W{1'b0}});
        end else begin
          act_duty <= slew_step(act_duty, cmd_duty);
        end
      end
`else
      if (&cnt) begin
        act_duty <= stop ? '0 : cmd_duty;
        act_dir  <= cmd_dir;
      end
`endif
    end
  end

  assign pwm = (cnt < act_duty);

endmodule

// File: rtl/chase_motor_ctrl.sv
// rtl/chase_motor_ctrl.sv - frame-driven chase FSM with lost-target search and frame watchdog
// Optional SLEW_LIMIT_EN (passed to pwm_gen) limits duty slew at each PWM wrap.
module chase_motor_ctrl
  import chase_pkg::*;
#(
  parameter int X_CENTER    = 160,
  parameter int X_DB        = 12,
  parameter int R_DB        = 3,
  parameter int KX_SHIFT    = 1,
  parameter int KR_SHIFT    = 3,
  parameter int DUTY_MAX    = 200,
  parameter int SEARCH_DUTY = 96,
  parameter int LOST_FRAMES = 16,
  parameter int WDOG_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_valid,
  input  logic [8:0] x,
  input  logic [6:0] rad,
  input  logic [6:0] goal_rad,
  input  logic       target_valid,
  output logic       mot_l_dir,
  output logic       mot_r_dir,
  output logic       mot_l_pwm,
  output logic       mot_r_pwm,
  output logic [2:0] state
);

  localparam int LW = $clog2(LOST_FRAMES + 1);
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  state_t             cur_state, next_state;
  logic [DUTY_W-1:0]  duty, next_duty;
  logic [LW-1:0]      lost_cnt, next_lost;
  logic [WW-1:0]      wdog_cnt, next_wdog;

  logic signed [9:0]  ex;
  logic signed [7:0]  er;
  logic signed [9:0]  er_ext;
  logic [9:0]         ex_abs, er_abs;
  logic [DUTY_W-1:0]  turn_duty, drive_duty;
  logic               dir_l, dir_r;

  assign ex         = $signed({1'b0, x}) - $signed(10'(X_CENTER));
  assign er         = $signed({1'b0, goal_rad}) - $signed({1'b0, rad});
  assign er_ext     = {{2{er[7]}}, er};
  assign ex_abs     = abs10(ex);
  assign er_abs     = abs10(er_ext);
  assign turn_duty  = sat_duty(ex, KX_SHIFT, DUTY_MAX);
  assign drive_duty = sat_duty(er_ext, KR_SHIFT, DUTY_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= STOP;
      duty      <= '0;
      lost_cnt  <= '0;
      wdog_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      duty      <= next_duty;
      lost_cnt  <= next_lost;
      wdog_cnt  <= next_wdog;
    end
  end

  always_comb begin
    next_state = cur_state;
    next_duty  = duty;
    next_lost  = lost_cnt;
    next_wdog  = wdog_cnt;
    // A frame on the terminal watchdog cycle takes precedence over the forced stop.
    if (frame_valid) begin
      next_wdog = '0;
      if (!target_valid) begin
        if (lost_cnt < LW'(LOST_FRAMES)) next_lost = lost_cnt + 1'b1;
        if (lost_cnt >= LW'(LOST_FRAMES - 1)) begin
          next_state = SEARCH;
          next_duty  = DUTY_W'(SEARCH_DUTY);
        end
      end else begin
        next_lost = '0;
        if (ex_abs > 10'(X_DB)) begin
          next_state = ex[9] ? TURN_L : TURN_R;
          next_duty  = turn_duty;
        end else if (er_abs > 10'(R_DB)) begin
          next_state = er[7] ? REV : FWD;
          next_duty  = drive_duty;
        end else begin
          next_state = HOLD;
          next_duty  = '0;
        end
      end
    end else if (wdog_cnt >= WW'(WDOG_CYCLES - 1)) begin
      next_wdog  = WW'(WDOG_CYCLES);
      next_state = STOP;
      next_duty  = '0;
    end else begin
      next_wdog = wdog_cnt + 1'b1;
    end
  end

  always_comb begin
    dir_l = 1'b1;
    dir_r = 1'b1;
    case (cur_state)
      TURN_L:         dir_l = 1'b0;
      TURN_R, SEARCH: dir_r = 1'b0;
      REV: begin
        dir_l = 1'b0;
        dir_r = 1'b0;
      end
      default: ;
    endcase
  end

  pwm_gen u_pwm_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_duty (duty),
    .cmd_dir  (dir_l),
    .stop     (cur_state == STOP),
    .pwm      (mot_l_pwm),
    .act_dir  (mot_l_dir)
  );

  pwm_gen u_pwm_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_duty (duty),
    .cmd_dir  (dir_r),
    .stop     (cur_state == STOP),
    .pwm      (mot_r_pwm),
    .act_dir  (mot_r_dir)
  );

  assign state = cur_state;

endmodule

// File: tb/tb_chase_motor_ctrl.sv
// tb/tb_chase_motor_ctrl.sv - directed and randomized frame stimulus against a frame-level model
module tb_chase_motor_ctrl;

  localparam int WDOG = 600;

  logic       clk = 1'b0;
  logic       rst_n, frame_valid, target_valid;
  logic [8:0] x;
  logic [6:0] rad, goal_rad;
  logic       mot_l_dir, mot_r_dir, mot_l_pwm, mot_r_pwm;
  logic [2:0] state;

  int n_vec = 0;
  int n_bad = 0;

  int m_state, m_duty, m_lost, m_wdog, m_cnt, m_act, m_dir_l, m_dir_r;

  always #5 clk = ~clk;

  chase_motor_ctrl #(.WDOG_CYCLES(WDOG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_valid  (frame_valid),
    .x            (x),
    .rad          (rad),
    .goal_rad     (goal_rad),
    .target_valid (target_valid),
    .mot_l_dir    (mot_l_dir),
    .mot_r_dir    (mot_r_dir),
    .mot_l_pwm    (mot_l_pwm),
    .mot_r_pwm    (mot_r_pwm),
    .state        (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Wheel direction for each drive decision, 1 = forward.
  function automatic int wheel_dir(input int st, input bit left);
    case (st)
      2:       return left ? 0 : 1;
      3, 6:    return left ? 1 : 0;
      5:       return 0;
      default: return 1;
    endcase
  endfunction

  task automatic model_edge();
    int ex, er;
    if (!rst_n) begin
      m_state = 0; m_duty = 0; m_lost = 0; m_wdog = 0;
      m_cnt = 0; m_act = 0; m_dir_l = 1; m_dir_r = 1;
      return;
    end
    if (m_cnt == 255) begin
      m_act   = m_duty;
      m_dir_l = wheel_dir(m_state, 1'b1);
      m_dir_r = wheel_dir(m_state, 1'b0);
    end
    m_cnt = (m_cnt + 1) % 256;
    if (frame_valid) begin
      m_wdog = 0;
      if (!target_valid) begin
        m_lost = imin(m_lost + 1, 16);
        if (m_lost >= 16) begin
          m_state = 6;
          m_duty  = 96;
        end
      end else begin
        m_lost = 0;
        ex = int'(x) - 160;
        er = int'(goal_rad) - int'(rad);
        if (iabs(ex) > 12) begin
          m_state = (ex > 0) ? 3 : 2;
          m_duty  = imin(iabs(ex) * 2, 200);
        end else if (iabs(er) > 3) begin
          m_state = (er > 0) ? 4 : 5;
          m_duty  = imin(iabs(er) * 8, 200);
        end else begin
          m_state = 1;
          m_duty  = 0;
        end
      end
    end else if (m_wdog + 1 >= WDOG) begin
      m_wdog  = WDOG;
      m_state = 0;
      m_duty  = 0;
    end else begin
      m_wdog++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("state", 32'(state), m_state);
    check_eq("pwm_l", 32'(mot_l_pwm), (m_cnt < m_act) ? 1 : 0);
    check_eq("pwm_r", 32'(mot_r_pwm), (m_cnt < m_act) ? 1 : 0);
    check_eq("dir_l", 32'(mot_l_dir), m_dir_l);
    check_eq("dir_r", 32'(mot_r_dir), m_dir_r);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input int xv, input int rv, input int gv, input bit tv);
    x            = 9'(xv);
    rad          = 7'(rv);
    goal_rad     = 7'(gv);
    target_valid = tv;
    frame_valid  = 1'b1;
    tick();
    frame_valid  = 1'b0;
  endtask

  task automatic wait_wrap();
    do tick(); while (m_cnt != 0);
  endtask

  task automatic high_count(output int hl, output int hr);
    hl = 0;
    hr = 0;
    repeat (256) begin
      hl += int'(mot_l_pwm);
      hr += int'(mot_r_pwm);
      tick();
    end
  endtask

  initial begin
    int hl, hr, r, xv, gv, rv, gap;
    rst_n = 1'b0; frame_valid = 1'b0; target_valid = 1'b0;
    x = 9'd160; rad = 7'd30; goal_rad = 7'd30;

    idle(3);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_pwm_l", 32'(mot_l_pwm), 0);
    check_eq("rst_pwm_r", 32'(mot_r_pwm), 0);
    check_eq("rst_dir_l", 32'(mot_l_dir), 1);
    check_eq("rst_dir_r", 32'(mot_r_dir), 1);
    rst_n = 1'b1;
    idle(WDOG + 50);
    check_eq("noframe_state", 32'(state), 0);

    send_frame(200, 30, 30, 1'b1);
    check_eq("turn_r_state", 32'(state), 3);
    wait_wrap();
    check_eq("turn_r_dir_l", 32'(mot_l_dir), 1);
    check_eq("turn_r_dir_r", 32'(mot_r_dir), 0);
    high_count(hl, hr);
    check_eq("turn_r_high_l", hl, 80);
    check_eq("turn_r_high_r", hr, 80);

    send_frame(160, 20, 30, 1'b1);
    check_eq("fwd_state", 32'(state), 4);
    wait_wrap();
    high_count(hl, hr);
    check_eq("fwd_high_l", hl, 80);
    send_frame(160, 40, 30, 1'b1);
    check_eq("rev_state", 32'(state), 5);
    check_eq("rev_dir_prewrap", 32'(mot_l_dir), 1);
    wait_wrap();
    check_eq("rev_dir_l", 32'(mot_l_dir), 0);
    check_eq("rev_dir_r", 32'(mot_r_dir), 0);

    send_frame(165, 31, 30, 1'b1);
    check_eq("hold_state", 32'(state), 1);
    idle(4);
    send_frame(100, 30, 30, 1'b1);
    check_eq("turn_l_state", 32'(state), 2);
    wait_wrap();
    check_eq("turn_l_dir_l", 32'(mot_l_dir), 0);
    check_eq("turn_l_dir_r", 32'(mot_r_dir), 1);
    high_count(hl, hr);
    check_eq("turn_l_high_r", hr, 120);

    send_frame(200, 30, 30, 1'b1);
    for (int i = 0; i < 15; i++) begin
      send_frame(160, 30, 30, 1'b0);
      idle(2);
    end
    check_eq("lost15_state", 32'(state), 3);
    send_frame(160, 30, 30, 1'b0);
    check_eq("lost16_state", 32'(state), 6);
    wait_wrap();
    high_count(hl, hr);
    check_eq("search_high_l", hl, 96);
    check_eq("search_high_r", hr, 96);
    send_frame(160, 30, 30, 1'b1);
    check_eq("refound_state", 32'(state), 1);

    send_frame(160, 20, 30, 1'b1);
    idle(WDOG - 1);
    check_eq("wdog_pre_state", 32'(state), 4);
    idle(1);
    check_eq("wdog_stop_state", 32'(state), 0);
    wait_wrap();
    high_count(hl, hr);
    check_eq("wdog_high_l", hl, 0);

    send_frame(160, 20, 30, 1'b1);
    idle(WDOG - 1);
    send_frame(200, 30, 30, 1'b1);
    check_eq("wdog_race_state", 32'(state), 3);

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      xv  = (r < 3) ? int'($urandom_range(0, 511)) : int'($urandom_range(130, 190));
      gv  = int'($urandom_range(10, 60));
      rv  = int'($urandom_range(gv - 10, gv + 10));
      gap = (r == 1) ? int'($urandom_range(WDOG - 3, WDOG + 3)) : int'($urandom_range(0, 60));
      send_frame(xv, rv, gv, $urandom_range(0, 4) != 0);
      idle(gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
